// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the RV32I multi-cycle control slice.
//   - Opcode constants for every supported instruction class.
//   - ALU operation codes and branch-condition codes (both ride on aluControl).
//   - Register-file write-data select codes.
//   - Control FSM state enum and the per-instruction decode bundle.
package rv32i_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  // ALU codes are {func7[5], func3}
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SLL  = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] SRL  = 4'b0101;
  localparam logic [3:0] SRA  = 4'b1101;
  localparam logic [3:0] OR   = 4'b0110;
  localparam logic [3:0] AND  = 4'b0111;

  // Branch codes are {1'b0, func3}
  localparam logic [3:0] BEQ  = 4'b0000;
  localparam logic [3:0] BNE  = 4'b0001;
  localparam logic [3:0] BLT  = 4'b0100;
  localparam logic [3:0] BGE  = 4'b0101;
  localparam logic [3:0] BLTU = 4'b0110;
  localparam logic [3:0] BGEU = 4'b0111;

  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_LOAD  = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_PCIMM = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  typedef enum logic [3:0] {
    FETCH, DECODE,
    R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM,
    L_EXE, L_MEM, L_WB
  } state_e;

  // Values latched when leaving DECODE and held until the next DECODE
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] rfwd_sel;
    logic [1:0] bus_size;
  } dec_t;

endpackage

// File: rtl/rv32i_main_decoder.sv
// rv32i_main_decoder: combinational main decoder.
//   instrCode  in  32  instruction word
//   o_next     out     state to enter after DECODE (FETCH when illegal)
//   o_dec      out     decode-value bundle (all zero when illegal)
//   o_illegal  out  1  opcode not recognised
module rv32i_main_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instrCode,
  output state_e      o_next,
  output dec_t        o_dec,
  output logic        o_illegal
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_unused;

  assign w_op     = instrCode[6:0];
  assign w_f3     = instrCode[14:12];
  assign w_f7b5   = instrCode[30];
  // register indices and immediates belong to the datapath
  assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  always_comb begin
    o_next    = FETCH;
    o_dec     = '0;
    o_illegal = 1'b0;
    case (w_op)
      OP_TYPE_R: begin
        o_next         = R_EXE;
        o_dec.alu_ctrl = {w_f7b5, w_f3};
      end
      OP_TYPE_I: begin
        o_next         = I_EXE;
        // bit30 is immediate data except on shift-right, where it picks SRA
        o_dec.alu_ctrl = {w_f7b5 & (w_f3 == 3'b101), w_f3};
        o_dec.alu_src  = 1'b1;
      end
      OP_TYPE_B: begin
        o_next         = B_EXE;
        o_dec.alu_ctrl = {1'b0, w_f3};
        o_dec.branch   = 1'b1;
      end
      OP_TYPE_LU: begin
        o_next         = LU_EXE;
        o_dec.rfwd_sel = RFWD_IMM;
      end
      OP_TYPE_AU: begin
        o_next         = AU_EXE;
        o_dec.rfwd_sel = RFWD_PCIMM;
      end
      OP_TYPE_J: begin
        o_next         = J_EXE;
        o_dec.jal      = 1'b1;
        o_dec.rfwd_sel = RFWD_PC4;
      end
      OP_TYPE_JL: begin
        o_next         = JL_EXE;
        o_dec.jal      = 1'b1;
        o_dec.jalr     = 1'b1;
        o_dec.rfwd_sel = RFWD_PC4;
      end
      OP_TYPE_S: begin
        o_next         = S_EXE;
        o_dec.alu_src  = 1'b1;
        o_dec.bus_size = w_f3[1:0];
      end
      OP_TYPE_L: begin
        o_next         = L_EXE;
        o_dec.alu_src  = 1'b1;
        o_dec.rfwd_sel = RFWD_LOAD;
        o_dec.bus_size = w_f3[1:0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: FSM control unit for the RV32I multi-cycle datapath.
//   clk, reset (async, active-high)
//   instrCode, busReady           : instruction word, data-bus ready
//   PCEn, regFileWe               : PC load / register write enables
//   aluControl, aluSrcMuxSel,
//   RFWDSrcMuxSel, branch, jal,
//   jalr, busSize                 : held decode values
//   busWe, busRe                  : data-bus request
//   instrRetired, illegalInstr,
//   busError                      : one-cycle event pulses
// BUS_TIMEOUT (1..255): wait cycles allowed in a MEM state before aborting.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic        busRe,
  output logic [1:0]  busSize,
  output logic        instrRetired,
  output logic        illegalInstr,
  output logic        busError
);

  localparam logic [7:0] TIMEOUT = 8'(BUS_TIMEOUT);

  state_e     r_state, w_next, w_dec_next;
  dec_t       r_dec, w_dec;
  logic       w_illegal;
  logic [7:0] r_wait;
  logic       w_limit;

  rv32i_main_decoder u_dec (
    .instrCode (instrCode),
    .o_next    (w_dec_next),
    .o_dec     (w_dec),
    .o_illegal (w_illegal)
  );

  assign w_limit = (r_wait == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Held through the following FETCH so the PC mux still sees this
  // instruction's branch/jal selection when the next PC is loaded.
  // An illegal opcode loads all zeros, giving a plain PC+4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_dec <= '0;
    else if (r_state == DECODE) r_dec <= w_dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_wait <= '0;
    else if (r_state == S_EXE || r_state == L_EXE)
      r_wait <= '0;
    else if ((r_state == S_MEM || r_state == L_MEM) && !busReady && !w_limit)
      r_wait <= r_wait + 8'd1;
  end

  always_comb begin
    w_next       = r_state;
    PCEn         = 1'b0;
    regFileWe    = 1'b0;
    busWe        = 1'b0;
    busRe        = 1'b0;
    instrRetired = 1'b0;
    illegalInstr = 1'b0;
    busError     = 1'b0;
    case (r_state)
      FETCH: begin
        PCEn   = 1'b1;
        w_next = DECODE;
      end
      DECODE: begin
        illegalInstr = w_illegal;
        w_next       = w_dec_next;
      end
      R_EXE, I_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE: begin
        regFileWe    = 1'b1;
        instrRetired = 1'b1;
        w_next       = FETCH;
      end
      B_EXE: begin
        instrRetired = 1'b1;
        w_next       = FETCH;
      end
      S_EXE: w_next = S_MEM;
      S_MEM: begin
        // request dropped in the limit cycle; a late ready there still wins
        busWe = !w_limit;
        if (busReady) begin
          instrRetired = 1'b1;
          w_next       = FETCH;
        end else if (w_limit) begin
          busError = 1'b1;
          w_next   = FETCH;
        end
      end
      L_EXE: w_next = L_MEM;
      L_MEM: begin
        busRe = !w_limit;
        if (busReady) begin
          w_next = L_WB;
        end else if (w_limit) begin
          busError = 1'b1;
          w_next   = FETCH;
        end
      end
      L_WB: begin
        regFileWe    = 1'b1;
        instrRetired = 1'b1;
        w_next       = FETCH;
      end
      default: w_next = FETCH;
    endcase
    // reset silences every enable at once, not at the next edge
    if (reset) begin
      PCEn         = 1'b0;
      regFileWe    = 1'b0;
      busWe        = 1'b0;
      busRe        = 1'b0;
      instrRetired = 1'b0;
      illegalInstr = 1'b0;
      busError     = 1'b0;
    end
  end

  assign aluControl    = r_dec.alu_ctrl;
  assign aluSrcMuxSel  = r_dec.alu_src;
  assign RFWDSrcMuxSel = r_dec.rfwd_sel;
  assign branch        = r_dec.branch;
  assign jal           = r_dec.jal;
  assign jalr          = r_dec.jalr;
  assign busSize       = r_dec.bus_size;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl: table-driven cycle-by-cycle check of the control
// FSM (BUS_TIMEOUT=4), plus a hand-written async-reset-in-L_MEM sequence.
// Output vector bit map:
//   19 PCEn, 18 regFileWe, 17:14 aluControl, 13 aluSrcMuxSel,
//   12:10 RFWDSrcMuxSel, 9 branch, 8 jal, 7 jalr, 6 busWe, 5 busRe,
//   4:3 busSize, 2 instrRetired, 1 illegalInstr, 0 busError
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
  logic        busWe, busRe, instrRetired, illegalInstr, busError;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic [1:0]  busSize;

  rv32i_multicycle_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .PCEn(PCEn), .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch(branch), .jal(jal), .jalr(jalr), .busWe(busWe), .busRe(busRe),
    .busSize(busSize), .instrRetired(instrRetired),
    .illegalInstr(illegalInstr), .busError(busError)
  );

  always #5 clk = ~clk;

  logic [19:0] got;
  assign got = {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                branch, jal, jalr, busWe, busRe, busSize,
                instrRetired, illegalInstr, busError};

  localparam logic [19:0] E_PC  = 20'h80000;
  localparam logic [19:0] E_WE  = 20'h40000;
  localparam logic [19:0] E_AS  = 20'h02000;
  localparam logic [19:0] E_BR  = 20'h00200;
  localparam logic [19:0] E_J   = 20'h00100;
  localparam logic [19:0] E_JR  = 20'h00080;
  localparam logic [19:0] E_BW  = 20'h00040;
  localparam logic [19:0] E_BRE = 20'h00020;
  localparam logic [19:0] E_RET = 20'h00004;
  localparam logic [19:0] E_ILL = 20'h00002;
  localparam logic [19:0] E_BE  = 20'h00001;

  function automatic logic [19:0] al(input logic [3:0] x); return {2'b0, x, 14'b0}; endfunction
  function automatic logic [19:0] sl(input logic [2:0] x); return {7'b0, x, 10'b0}; endfunction
  function automatic logic [19:0] bz(input logic [1:0] x); return {15'b0, x, 3'b0}; endfunction

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h4032D293;
  localparam logic [31:0] I_SRLI  = 32'h0032D293;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_AUIPC = 32'h00000117;
  localparam logic [31:0] I_LW    = 32'h00802203;
  localparam logic [31:0] I_SW    = 32'h00402423;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic [31:0] ins, input logic rdy, input logic [19:0] e);
    vec_t v;
    v.ins = ins; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h (%b) expected %05h (%b)", name, act, act, exp, exp);
    end
  endtask

  initial begin
    // ADD: FETCH, DECODE, R_EXE
    add(I_ADD,   0, E_PC);
    add(I_ADD,   0, '0);
    add(I_ADD,   0, E_WE | E_RET);
    // SRAI -> SRA with immediate
    add(I_SRAI,  0, E_PC);
    add(I_SRAI,  0, '0);
    add(I_SRAI,  0, E_WE | al(4'b1101) | E_AS | E_RET);
    // SRLI -> SRL; previous decode values still held in FETCH/DECODE
    add(I_SRLI,  0, E_PC | al(4'b1101) | E_AS);
    add(I_SRLI,  0, al(4'b1101) | E_AS);
    add(I_SRLI,  0, E_WE | al(4'b0101) | E_AS | E_RET);
    // BEQ: no register write; branch held into the next-PC load
    add(I_BEQ,   0, E_PC | al(4'b0101) | E_AS);
    add(I_BEQ,   0, al(4'b0101) | E_AS);
    add(I_BEQ,   0, E_BR | E_RET);
    // LUI
    add(I_LUI,   0, E_PC | E_BR);
    add(I_LUI,   0, E_BR);
    add(I_LUI,   0, E_WE | sl(3'd2) | E_RET);
    // JAL
    add(I_JAL,   0, E_PC | sl(3'd2));
    add(I_JAL,   0, sl(3'd2));
    add(I_JAL,   0, E_WE | E_J | sl(3'd4) | E_RET);
    // JALR
    add(I_JALR,  0, E_PC | E_J | sl(3'd4));
    add(I_JALR,  0, E_J | sl(3'd4));
    add(I_JALR,  0, E_WE | E_J | E_JR | sl(3'd4) | E_RET);
    // AUIPC
    add(I_AUIPC, 0, E_PC | E_J | E_JR | sl(3'd4));
    add(I_AUIPC, 0, E_J | E_JR | sl(3'd4));
    add(I_AUIPC, 0, E_WE | sl(3'd3) | E_RET);
    // LW, ready after 2 wait cycles: 7 cycles FETCH..retire
    add(I_LW,    0, E_PC | sl(3'd3));
    add(I_LW,    0, sl(3'd3));
    add(I_LW,    0, E_AS | sl(3'd1) | bz(2'd2));
    add(I_LW,    0, E_BRE | E_AS | sl(3'd1) | bz(2'd2));
    add(I_LW,    0, E_BRE | E_AS | sl(3'd1) | bz(2'd2));
    add(I_LW,    1, E_BRE | E_AS | sl(3'd1) | bz(2'd2));
    add(I_LW,    0, E_WE | E_AS | sl(3'd1) | bz(2'd2) | E_RET);
    // SW (rd field nonzero), never ready: 4 request cycles then busError
    add(I_SW,    0, E_PC | E_AS | sl(3'd1) | bz(2'd2));
    add(I_SW,    0, E_AS | sl(3'd1) | bz(2'd2));
    add(I_SW,    0, E_AS | bz(2'd2));
    for (int k = 0; k < 4; k++) add(I_SW, 0, E_BW | E_AS | bz(2'd2));
    add(I_SW,    0, E_AS | bz(2'd2) | E_BE);
    // illegal opcode: pulse in DECODE, decode values cleared afterwards
    add(I_ILL,   0, E_PC | E_AS | bz(2'd2));
    add(I_ILL,   0, E_AS | bz(2'd2) | E_ILL);
    // SW with ready arriving exactly in the limit cycle: success
    add(I_SW,    0, E_PC);
    add(I_SW,    0, '0);
    add(I_SW,    0, E_AS | bz(2'd2));
    for (int k = 0; k < 4; k++) add(I_SW, 0, E_BW | E_AS | bz(2'd2));
    add(I_SW,    1, E_AS | bz(2'd2) | E_RET);
    add(I_ADD,   0, E_PC | E_AS | bz(2'd2));

    reset = 1'b1; instrCode = I_ADD; busReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", got, '0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      instrCode = tbl[i].ins;
      busReady  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl[%0d]", i), got, tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // reset asserted in the middle of an L_MEM wait
    @(negedge clk);
    reset = 1'b1; busReady = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    instrCode = I_LW;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lmem_before_reset", got, E_BRE | E_AS | sl(3'd1) | bz(2'd2));
    reset = 1'b1;
    #1;
    chk("lmem_async_reset", got, '0);
    @(posedge clk);
    #1;
    chk("reset_held", got, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_after_reset", got, E_PC);
    @(negedge clk);
    chk("decode_after_reset", got, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- FSM control unit that sequences the RV32I multi-cycle datapath.
- Decodes the held instruction word and drives the datapath controls PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal and jalr.
- Owns the data-bus request/ready handshake, including a bounded wait with timeout.
- Reports retirement, illegal-opcode and bus-error events.

Parameters:
- BUS_TIMEOUT, 16, maximum number of cycles a MEM state waits for busReady before aborting; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- instrCode  in  32  current instruction word; stable while PC is held.
- busReady  in  1  data-bus ready; read data is valid in the cycle busReady=1.
- PCEn  out  1  PC register load enable.
- regFileWe  out  1  register-file write enable.
- aluControl  out  4  ALU operation / branch condition.
- aluSrcMuxSel  out  1  ALU operand B select: 0 = rs2, 1 = immediate.
- RFWDSrcMuxSel  out  3  write-data select: 0 = ALU, 1 = load data, 2 = immediate, 3 = PC+imm, 4 = PC+4.
- branch  out  1  instruction is a conditional branch.
- jal  out  1  PC source is PC+imm (JAL, JALR).
- jalr  out  1  PC+imm adder base is rs1.
- busWe  out  1  data-bus write request.
- busRe  out  1  data-bus read request.
- busSize  out  2  access size, func3[1:0].
- instrRetired  out  1  one-cycle pulse in the last state of each completed instruction.
- illegalInstr  out  1  one-cycle pulse on an undecodable opcode.
- busError  out  1  one-cycle pulse on a bus timeout.

Behaviour:
- Reset values:
  - State = FETCH.
  - All outputs 0, except aluControl = ADD (4'b0000).
  - Wait counter = 0.
  - Reset mid-instruction aborts immediately; no writes occur after reset asserts.
- FETCH (1 cycle):
  - PCEn=1; all other enables 0.
  - Next state: DECODE.
- DECODE (1 cycle):
  - All enables 0; the datapath captures operands and immediate.
  - Next state is chosen by opcode: R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE or L_EXE.
  - Any other opcode: illegalInstr=1 and go to FETCH; PC advances +4.
- Per-instruction decode values are registered when leaving DECODE. They hold in every state from EXE through the last state of the instruction, so the next PC is still valid when it is captured:
  - aluControl, aluSrcMuxSel, branch, jal, jalr, RFWDSrcMuxSel, busSize.
- aluControl rules:
  - R-type: {func7[5], func3}.
  - I-type: {func7[5] & (func3==3'b101), func3}.
  - B-type: {1'b0, func3}.
  - L, S, JL, AU: ADD.
- Single-cycle EXE states, each with regFileWe=1 and instrRetired=1, then FETCH:
  - R_EXE: sel 0.
  - I_EXE: sel 0, aluSrcMuxSel=1.
  - LU_EXE: sel 2.
  - AU_EXE: sel 3.
  - J_EXE: jal=1, sel 4.
  - JL_EXE: jal=1, jalr=1, sel 4.
- B_EXE: branch=1, regFileWe=0, instrRetired=1, then FETCH.
- Store sequence:
  - S_EXE: aluSrcMuxSel=1, then S_MEM.
  - S_MEM: busWe=1 held until busReady.
  - On busReady: instrRetired=1, then FETCH.
- Load sequence:
  - L_EXE: aluSrcMuxSel=1, then L_MEM.
  - L_MEM: busRe=1 held until busReady, then L_WB.
  - L_WB: regFileWe=1, sel 1, instrRetired=1, then FETCH.
- Wait counter and timeout:
  - The counter clears on MEM entry and increments each MEM cycle with busReady=0.
  - When it reaches BUS_TIMEOUT with busReady still 0: busError=1, drop the request, no register write, go to FETCH.
  - busReady in the same cycle as the limit counts as success; ready wins.
- Stores with rd field bits ≠ 0 never write the register file: regFileWe is 0 in all S states.
- Latency in cycles, FETCH to retire:
  - R, I, B, LU, AU, J, JL: 3.
  - S: 4 + w.
  - L: 5 + w.
  - w = number of wait cycles.

Decomposition:
- Shared package rv32i_pkg holds:
  - Opcode constants OP_TYPE_R/L/S/I/B/LU/AU/J/JL.
  - ALU codes ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Branch codes BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - RFWD select constants.
  - The FSM state enum.
- One sub-module, rv32i_main_decoder: combinational mapping from instrCode to the decode-value bundle and an illegal flag.
- The FSM, the decode-value holding registers and the wait counter stay in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3): FETCH, DECODE, R_EXE. PCEn only in FETCH; regFileWe=1, aluControl=0000, sel 0 in R_EXE; instrRetired at cycle 3.
- SRAI x5,x5,3 (0x4032D293) → aluControl=1101, aluSrcMuxSel=1. SRLI (0x0032D293) → 0101.
- BEQ (0x00208463) → B_EXE with branch=1, aluControl=0000, regFileWe=0. branch holds through the next-PC capture; the next FETCH has PCEn=1.
- LW x4,8(x0) (0x00802203) with busReady after 2 wait cycles:
  - busRe high for 3 cycles.
  - L_WB: regFileWe=1, sel 1.
  - 7 cycles from FETCH to retire.
- SW (0x00402423) with BUS_TIMEOUT=4, busReady never:
  - busWe high for 4 cycles, then busError pulse, FETCH.
  - No regFileWe and no instrRetired.
- Opcode 0x0000007F → illegalInstr pulse in DECODE, then FETCH. Reset asserted mid-L_MEM → all outputs 0 immediately, FETCH after release.
